// File: rtl/ula_seq_ctrl.sv
// Multi-byte sequencer for a shared ula_8_bits: runs one pass per byte, LSB first, rippling carry.
// Optional ULA_SEQ_CTRL_STATS_EN adds saturating op_count / carry_count outputs.
module ula_seq_ctrl #(
    parameter int N_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [8*N_BYTES-1:0]   req_a,
    input  logic [8*N_BYTES-1:0]   req_b,
    input  logic [3:0]             req_s,
    input  logic                   req_m,
    input  logic                   req_c_in,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_c_in,
    input  logic [7:0]             alu_f,
    input  logic                   alu_c_out,
    input  logic                   alu_a_eq_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [8*N_BYTES-1:0]   resp_f,
    output logic                   resp_c_out,
    output logic                   resp_a_eq_b,
`ifdef ULA_SEQ_CTRL_STATS_EN
    output logic [15:0]            op_count,
    output logic [15:0]            carry_count,
`endif
    output logic                   busy
);

    localparam int W  = 8 * N_BYTES;
    localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [KW-1:0] LAST = KW'(N_BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [3:0]    s_q, s_d;
    logic          m_q, m_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic          eq_q, eq_d;
    logic [W-1:0]  f_q, f_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        f_d     = f_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    s_d     = req_s;
                    m_d     = req_m;
                    cin_d   = req_c_in;
                    k_d     = '0;
                    eq_d    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each edge retires the current byte pass into the result and carry/eq state
                f_d[8*k_q +: 8] = alu_f;
                carry_d         = alu_c_out;
                eq_d            = eq_q & alu_a_eq_b;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            f_q     <= f_d;
        end
    end

    // ALU port is only driven while a pass is in flight; pass 0 takes the command carry
    always_comb begin
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_s    = 4'd0;
        alu_m    = 1'b0;
        alu_c_in = 1'b0;
        if (state_q == RUN) begin
            alu_a    = a_q[8*k_q +: 8];
            alu_b    = b_q[8*k_q +: 8];
            alu_s    = s_q;
            alu_m    = m_q;
            alu_c_in = (k_q == '0) ? cin_q : carry_q;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_f      = f_q;
    assign resp_c_out  = carry_q;
    assign resp_a_eq_b = eq_q;

`ifdef ULA_SEQ_CTRL_STATS_EN
    logic [15:0] op_cnt_q;
    logic [15:0] carry_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q    <= 16'd0;
            carry_cnt_q <= 16'd0;
        end else if (state_q == DONE && resp_ready) begin
            if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
            if (carry_q && carry_cnt_q != 16'hFFFF) carry_cnt_q <= carry_cnt_q + 16'd1;
        end
    end

    assign op_count    = op_cnt_q;
    assign carry_count = carry_cnt_q;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl (N_BYTES=2) with a behavioural 8-bit ALU stub and a whole-operation reference model.
module tb_ula_seq_ctrl;

    localparam int N = 2;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   req_s;
    logic         req_m, req_c_in;
    logic [7:0]   alu_a, alu_b;
    logic [3:0]   alu_s;
    logic         alu_m, alu_c_in;
    logic [7:0]   alu_f;
    logic         alu_c_out, alu_a_eq_b;
    logic         resp_valid, resp_ready;
    logic [W-1:0] resp_f;
    logic         resp_c_out, resp_a_eq_b, busy;
`ifdef ULA_SEQ_CTRL_STATS_EN
    logic [15:0]  op_count, carry_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_seq_ctrl #(.N_BYTES(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_f(resp_f), .resp_c_out(resp_c_out), .resp_a_eq_b(resp_a_eq_b),
`ifdef ULA_SEQ_CTRL_STATS_EN
        .op_count(op_count), .carry_count(carry_count),
`endif
        .busy(busy)
    );

    // Behavioural 8-bit ALU: arithmetic a + op(b) + c_in, logic mode ignores carry
    function automatic logic [8:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic [3:0] s, input logic m);
        logic [7:0] ob, f;
        if (!m) begin
            case (s)
                4'd0:    ob = 8'd0;
                4'd1:    ob = b;
                4'd2:    ob = ~b;
                4'd3:    ob = a;
                default: ob = b ^ {s, s};
            endcase
            return {1'b0, a} + {1'b0, ob} + {8'd0, c};
        end
        case (s[1:0])
            2'd0:    f = a & b;
            2'd1:    f = a | b;
            2'd2:    f = a ^ b;
            default: f = ~a;
        endcase
        f = f ^ {8{s[2]}};
        if (s[3]) f = {f[3:0], f[7:4]};
        return {^f, f};
    endfunction

    logic [8:0] alu_r;
    always_comb begin
        alu_r      = alu8(alu_a, alu_b, alu_c_in, alu_s, alu_m);
        alu_f      = alu_r[7:0];
        alu_c_out  = alu_r[8];
        alu_a_eq_b = (alu_a == alu_b);
    end

    typedef struct packed {
        logic [W-1:0] f;
        logic         co;
        logic         eq;
        logic [N-1:0] cins;
    } res_t;

    // Whole-operand reference: plain addition for A+B+C, byte chain otherwise
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] s, input logic m, input logic c);
        res_t r;
        logic [W:0] sum;
        logic [W-1:0] mask;
        logic cc;
        logic [8:0] p;
        r.eq = (a == b);
        if (!m && s == 4'd1) begin
            sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r.f  = sum[W-1:0];
            r.co = sum[W];
            for (int k = 0; k < N; k++) begin
                mask      = (k == 0) ? '0 : ({W{1'b1}} >> (W - 8*k));
                sum       = {1'b0, a & mask} + {1'b0, b & mask} + {{W{1'b0}}, c};
                r.cins[k] = (k == 0) ? c : sum[8*k];
            end
        end else begin
            cc = c;
            for (int k = 0; k < N; k++) begin
                r.cins[k]      = cc;
                p              = alu8(a[8*k +: 8], b[8*k +: 8], cc, s, m);
                r.f[8*k +: 8]  = p[7:0];
                cc             = p[8];
            end
            r.co = cc;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 running pass m_k, 2 response pending
    int           m_ph = 0;
    int           m_k  = 0;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_s;
    logic         m_m;
    res_t         m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0;
            m_k  <= 0;
        end else begin
            case (m_ph)
                0: if (req_valid) begin
                    m_a   <= req_a;
                    m_b   <= req_b;
                    m_s   <= req_s;
                    m_m   <= req_m;
                    m_res <= ref_op(req_a, req_b, req_s, req_m, req_c_in);
                    m_k   <= 0;
                    m_ph  <= 1;
                end
                1: if (m_k == N - 1) begin
                    m_ph <= 2;
                    m_k  <= 0;
                end else begin
                    m_k <= m_k + 1;
                end
                default: if (resp_ready) m_ph <= 0;
            endcase
        end
    end

    logic [21:0] exp_bus;
    always @(negedge clk) begin
        chk("req_ready", req_ready, m_ph == 0);
        chk("busy", busy, m_ph != 0);
        chk("resp_valid", resp_valid, m_ph == 2);
        exp_bus = '0;
        if (m_ph == 1)
            exp_bus = {m_a[8*m_k +: 8], m_b[8*m_k +: 8], m_s, m_m, m_res.cins[m_k]};
        chk("alu_bus", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, exp_bus);
        if (m_ph == 2) begin
            chk("resp_f", resp_f, m_res.f);
            chk("resp_c_out", resp_c_out, m_res.co);
            chk("resp_a_eq_b", resp_a_eq_b, m_res.eq);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c, input int hold, input bit poke,
                          output logic [W-1:0] f, output logic co, output logic eq,
                          output int lat, output logic lastcin);
        @(negedge clk); #1;
        req_valid = 1'b1; req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = c;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom);
        req_m = 1'($urandom); req_c_in = 1'($urandom);
        lat = 0;
        lastcin = 1'b0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid) break;
            lastcin = alu_c_in;
            if (lat > 20) begin
                chk("resp_timeout", 0, 1);
                break;
            end
        end
        f = resp_f; co = resp_c_out; eq = resp_a_eq_b;
        for (int i = 0; i < hold; i++) begin
            #1;
            if (poke) begin
                req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom);
            end
            @(negedge clk);
            if (poke) begin
                chk("hold_valid", resp_valid, 1);
                chk("hold_f", resp_f, f);
                chk("hold_req_ready", req_ready, 0);
            end
        end
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [W-1:0] f;
    logic co, eq, lc;
    int lat, seen;
    res_t pin;
    logic [3:0] rs;
    logic rm;
    logic [W-1:0] ra, rb;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0;
        req_m = 1'b0; req_c_in = 1'b0; resp_ready = 1'b0;

        pin = ref_op(16'h00FF, 16'h0001, 4'd1, 1'b0, 1'b0);
        chk("model_add_f", pin.f, 16'h0100);
        chk("model_add_cin1", pin.cins[1], 1);
        pin = ref_op(16'hF03F, 16'h1C0A, 4'd1, 1'b0, 1'b0);
        chk("model_add2", {pin.co, pin.f}, 17'h10C49);
        pin = ref_op(16'hF03F, 16'h1C0A, 4'd0, 1'b1, 1'b0);
        chk("model_and", pin.f, 16'h100A);
        pin = ref_op(16'hF03F, 16'h1C0A, 4'd0, 1'b0, 1'b0);
        chk("model_passa", {pin.co, pin.f}, 17'h0F03F);

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", {resp_f, resp_c_out, resp_a_eq_b}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
        #1 rst = 1'b0;

`ifdef ULA_SEQ_CTRL_STATS_EN
        run_op(16'hFFFF, 16'h0001, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        run_op(16'h0001, 16'h0001, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        run_op(16'hFF00, 16'h0100, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        @(negedge clk);
        chk("op_count", op_count, 3);
        chk("carry_count", carry_count, 2);
        #1;
        force dut.op_cnt_q = 16'hFFFF;
        force dut.carry_cnt_q = 16'hFFFF;
        @(negedge clk); #1;
        release dut.op_cnt_q;
        release dut.carry_cnt_q;
        run_op(16'hFFFF, 16'h0001, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        @(negedge clk);
        chk("op_count_sat", op_count, 16'hFFFF);
        chk("carry_count_sat", carry_count, 16'hFFFF);
`endif

        run_op(16'h00FF, 16'h0001, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        chk("t1_f", f, 16'h0100);
        chk("t1_co", co, 0);
        chk("t1_lat", lat, N);
        chk("t1_pass1_cin", lc, 1);

        run_op(16'hFFFF, 16'h0001, 4'd1, 1'b0, 1'b0, 1, 1'b0, f, co, eq, lat, lc);
        chk("t2_f", f, 16'h0000);
        chk("t2_co", co, 1);
        run_op(16'h0000, 16'h0000, 4'd1, 1'b0, 1'b1, 0, 1'b0, f, co, eq, lat, lc);
        chk("t2b_f", f, 16'h0001);
        chk("t2b_eq", eq, 1);
        run_op(16'h1234, 16'h1234, 4'd1, 1'b0, 1'b0, 0, 1'b0, f, co, eq, lat, lc);
        chk("eq_f", f, 16'h2468);
        chk("eq_flag", eq, 1);

        for (int mi = 0; mi < 2; mi++) begin
            for (int si = 0; si < 16; si++) begin
                run_op(16'hF03F, 16'h1C0A, 4'(si), 1'(mi), 1'b0, 0, 1'b0, f, co, eq, lat, lc);
                pin = ref_op(16'hF03F, 16'h1C0A, 4'(si), 1'(mi), 1'b0);
                chk("t3_f", f, pin.f);
                chk("t3_eq", eq, 0);
            end
        end

        run_op(16'h7777, 16'h1111, 4'd1, 1'b0, 1'b1, 5, 1'b1, f, co, eq, lat, lc);
        chk("t4_f", f, 16'h8889);

        // Reset one cycle into a run must drop the operation with no response
        @(negedge clk); #1;
        req_valid = 1'b1; req_a = 16'hFFFF; req_b = 16'h0001; req_s = 4'd1; req_m = 1'b0; req_c_in = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_req_ready", req_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_alu", {alu_a, alu_b, alu_s, alu_m, alu_c_in}, 0);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("t5_no_resp", seen, 0);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 1) == 0) begin rs = 4'd1; rm = 1'b0; end
            else begin rs = 4'($urandom); rm = 1'($urandom); end
            run_op(ra, rb, rs, rm, 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                   f, co, eq, lat, lc);
            chk("rnd_lat", lat, N);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
